pic_inta_sequencer: RTL and testbench

Interrupt-acknowledge sequencer for the 8259 PIC, in 8086 mode. It sits between the CPU-side INTA pin and the interrupt block (IRR/ISR/priority resolver). It drives INT to the CPU, counts INTA pulses and produces the ISR set and clear strobes, including automatic EOI. It also places the interrupt vector on the data bus during the second INTA pulse.

---
 rtl/pic_pkg.sv | 22 ++
 rtl/pic_inta_edge.sv | 25 ++
 rtl/pic_inta_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 interrupt-acknowledge sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAck1,
        StGap,
        StAck2
    } pic_state_e;

    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    localparam logic [1:0] CNT_IDLE   = 2'b00;
    localparam logic [1:0] CNT_FIRST  = 2'b01;
    localparam logic [1:0] CNT_SECOND = 2'b10;

    function automatic logic [7:0] vector_byte(input logic [4:0] base, input logic [2:0] lvl);
        return {base, lvl};
    endfunction

endpackage

// File: rtl/pic_inta_edge.sv
// Registers the synchronous INTA strobe and produces registered one-cycle
// fall/rise pulses.
module pic_inta_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inta_n,
    output logic o_fall,
    output logic o_rise
);

    logic r_inta_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inta_q <= 1'b1;
            o_fall   <= 1'b0;
            o_rise   <= 1'b0;
        end else begin
            r_inta_q <= i_inta_n;
            o_fall   <= r_inta_q & ~i_inta_n;
            o_rise   <= ~r_inta_q & i_inta_n;
        end
    end

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-mode INTA sequencer: drives INT, counts INTA pulses, strobes ISR set/clear
// and presents the vector byte. Optional abort timeout: PIC_INTA_TIMEOUT_EN.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic [2:0] int_level,
    input  logic       inta_n,
    input  logic [4:0] vec_base,
    input  logic       aeoi,
    input  logic       eoi_cmd,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic       isr_set,
    output logic       isr_clr,
    output logic [2:0] isr_clr_level,
    output logic [1:0] inta_count,
    output logic [7:0] data_out,
    output logic       data_oe
);

    pic_state_e r_state;
    logic [2:0] r_lvl_q;
    logic       r_spur_q;
    logic       r_eoi_pend;
    logic [2:0] r_eoi_lvl;

    logic w_fall;
    logic w_rise;
    logic w_tmo_hit;
    logic w_auto_clr;

    pic_inta_edge u_edge (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_inta_n (inta_n),
        .o_fall   (w_fall),
        .o_rise   (w_rise)
    );

`ifdef PIC_INTA_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TmoW-1:0] r_tmo_cnt;
    logic            w_waiting;

    assign w_waiting = (r_state == StAck1) || (r_state == StGap);
    assign w_tmo_hit = w_waiting && !w_fall && !w_rise &&
                       (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_waiting || w_fall || w_rise) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_tmo_hit    = 1'b0;
`endif

    // An aborted sequence clears ISR the same way AEOI does, undoing the isr_set.
    assign w_auto_clr = !r_spur_q &&
                        ((r_state == StAck2 && w_rise && aeoi) || w_tmo_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_lvl_q       <= '0;
            r_spur_q      <= 1'b0;
            r_eoi_pend    <= 1'b0;
            r_eoi_lvl     <= '0;
            int_out       <= 1'b0;
            isr_set       <= 1'b0;
            isr_clr       <= 1'b0;
            isr_clr_level <= '0;
            inta_count    <= CNT_IDLE;
            data_out      <= '0;
            data_oe       <= 1'b0;
        end else begin
            isr_set <= 1'b0;

            // AEOI/timeout clear has priority; a colliding EOI waits one cycle.
            if (w_auto_clr) begin
                isr_clr       <= 1'b1;
                isr_clr_level <= r_lvl_q;
                if (eoi_cmd) begin
                    r_eoi_pend <= 1'b1;
                    r_eoi_lvl  <= eoi_level;
                end
            end else if (eoi_cmd) begin
                isr_clr       <= 1'b1;
                isr_clr_level <= eoi_level;
                r_eoi_pend    <= 1'b0;
            end else if (r_eoi_pend) begin
                isr_clr       <= 1'b1;
                isr_clr_level <= r_eoi_lvl;
                r_eoi_pend    <= 1'b0;
            end else begin
                isr_clr <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    int_out    <= 1'b0;
                    inta_count <= CNT_IDLE;
                    if (int_req) begin
                        r_state <= StReq;
                        int_out <= 1'b1;
                    end
                end
                StReq: begin
                    if (w_fall) begin
                        r_state    <= StAck1;
                        int_out    <= 1'b0;
                        inta_count <= CNT_FIRST;
                        if (int_req) begin
                            isr_set  <= 1'b1;
                            r_lvl_q  <= int_level;
                            r_spur_q <= 1'b0;
                        end else begin
                            r_lvl_q  <= SPURIOUS_LEVEL;
                            r_spur_q <= 1'b1;
                        end
                    end
                end
                StAck1: begin
                    if (w_rise) begin
                        r_state <= StGap;
                    end else if (w_tmo_hit) begin
                        r_state    <= StIdle;
                        inta_count <= CNT_IDLE;
                    end
                end
                StGap: begin
                    if (w_fall) begin
                        r_state    <= StAck2;
                        inta_count <= CNT_SECOND;
                        data_oe    <= 1'b1;
                        data_out   <= vector_byte(vec_base, r_lvl_q);
                    end else if (w_tmo_hit) begin
                        r_state    <= StIdle;
                        inta_count <= CNT_IDLE;
                    end
                end
                StAck2: begin
                    if (w_rise) begin
                        data_oe    <= 1'b0;
                        data_out   <= '0;
                        inta_count <= CNT_IDLE;
                        if (int_req) begin
                            r_state <= StReq;
                            int_out <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        data_out <= vector_byte(vec_base, r_lvl_q);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer; the abort sequence runs only when
// PIC_INTA_TIMEOUT_EN is defined.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       int_req = 1'b0;
    logic [2:0] int_level = '0;
    logic       inta_n = 1'b1;
    logic [4:0] vec_base = 5'h08;
    logic       aeoi = 1'b0;
    logic       eoi_cmd = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       int_out;
    logic       isr_set;
    logic       isr_clr;
    logic [2:0] isr_clr_level;
    logic [1:0] inta_count;
    logic [7:0] data_out;
    logic       data_oe;

    int n_checks = 0;
    int n_pass   = 0;
    int n_set    = 0;

    pic_inta_sequencer #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .int_req       (int_req),
        .int_level     (int_level),
        .inta_n        (inta_n),
        .vec_base      (vec_base),
        .aeoi          (aeoi),
        .eoi_cmd       (eoi_cmd),
        .eoi_level     (eoi_level),
        .int_out       (int_out),
        .isr_set       (isr_set),
        .isr_clr       (isr_clr),
        .isr_clr_level (isr_clr_level),
        .inta_count    (inta_count),
        .data_out      (data_out),
        .data_oe       (data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (isr_set === 1'b1) n_set++;

    typedef struct {
        logic       rst;
        logic       req;
        logic [2:0] lvl;
        logic       inta_n;
        logic       aeoi;
        logic       eoi;
        logic [2:0] eoi_lvl;
        logic       e_int;
        logic       e_set;
        logic       e_clr;
        logic [2:0] e_clr_lvl;
        logic [1:0] e_cnt;
        logic [7:0] e_data;
        logic       e_oe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rq, logic [2:0] l, logic ia, logic ae, logic e,
                                logic [2:0] el, logic xi, logic xs, logic xc,
                                logic [2:0] xl, logic [1:0] xn, logic [7:0] xd, logic xo);
        vec_t v;
        v.rst = r; v.req = rq; v.lvl = l; v.inta_n = ia; v.aeoi = ae; v.eoi = e;
        v.eoi_lvl = el; v.e_int = xi; v.e_set = xs; v.e_clr = xc; v.e_clr_lvl = xl;
        v.e_cnt = xn; v.e_data = xd; v.e_oe = xo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // A: AEOI sequence, level 1
        vecs.push_back(mk(1,0,1,1,1,0,0, 0,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,1,1,1,1,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,1,1,0,1,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,1,1,0,1,0,0, 0,1,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,0,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,1,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,1,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,0,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,0,1,0,0, 0,0,0,0,2,8'h41,1));
        vecs.push_back(mk(0,0,1,0,1,0,0, 0,0,0,0,2,8'h41,1));
        vecs.push_back(mk(0,0,1,1,1,0,0, 0,0,0,0,2,8'h41,1));
        vecs.push_back(mk(0,0,1,1,1,0,0, 0,0,1,1,0,8'h00,0));
        vecs.push_back(mk(0,0,1,1,1,0,0, 0,0,0,0,0,8'h00,0));
        // B: no AEOI, then a specific EOI for level 1
        vecs.push_back(mk(0,1,1,1,0,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,1,1,0,0,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,1,1,0,0,0,0, 0,1,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0,2,8'h41,1));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,0,0,0,2,8'h41,1));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,0,1,1,0,1,1, 0,0,1,1,0,8'h00,0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,0,0,0,0,8'h00,0));
        // C: request withdrawn before INTA -> spurious level 7
        vecs.push_back(mk(0,1,2,1,1,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,0,2,1,1,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,0,2,0,1,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,0,2,0,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,2,1,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,2,1,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,2,0,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,0,2,0,1,0,0, 0,0,0,0,2,8'h47,1));
        vecs.push_back(mk(0,0,2,1,1,0,0, 0,0,0,0,2,8'h47,1));
        vecs.push_back(mk(0,0,2,1,1,0,0, 0,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,0,2,1,1,0,0, 0,0,0,0,0,8'h00,0));
        // D: AEOI collides with EOI 3; request held -> back-to-back REQ
        vecs.push_back(mk(0,1,1,1,1,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,1,1,0,1,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,1,1,0,1,0,0, 0,1,0,0,1,8'h00,0));
        vecs.push_back(mk(0,1,1,1,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,1,1,1,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,1,1,0,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,1,1,0,1,0,0, 0,0,0,0,2,8'h41,1));
        vecs.push_back(mk(0,1,1,1,1,0,0, 0,0,0,0,2,8'h41,1));
        vecs.push_back(mk(0,1,1,1,1,1,3, 1,0,1,1,0,8'h00,0));
        vecs.push_back(mk(0,1,1,1,1,0,0, 1,0,1,3,0,8'h00,0));
        vecs.push_back(mk(0,1,4,1,1,0,0, 1,0,0,0,0,8'h00,0));
        // E: reset in the middle of ACK2, level 4
        vecs.push_back(mk(0,1,4,0,1,0,0, 1,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,1,4,0,1,0,0, 0,1,0,0,1,8'h00,0));
        vecs.push_back(mk(0,1,4,1,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,1,4,1,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,1,4,0,1,0,0, 0,0,0,0,1,8'h00,0));
        vecs.push_back(mk(0,1,4,0,1,0,0, 0,0,0,0,2,8'h44,1));
        vecs.push_back(mk(0,0,4,1,1,0,0, 0,0,0,0,2,8'h44,1));
        vecs.push_back(mk(1,0,4,1,1,0,0, 0,0,0,0,0,8'h00,0));
        vecs.push_back(mk(0,0,4,1,1,0,0, 0,0,0,0,0,8'h00,0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            int_req   = vecs[i].req;
            int_level = vecs[i].lvl;
            inta_n    = vecs[i].inta_n;
            aeoi      = vecs[i].aeoi;
            eoi_cmd   = vecs[i].eoi;
            eoi_level = vecs[i].eoi_lvl;
            tick();
            chk($sformatf("v%0d int_out", i), 8'(int_out), 8'(vecs[i].e_int));
            chk($sformatf("v%0d isr_set", i), 8'(isr_set), 8'(vecs[i].e_set));
            chk($sformatf("v%0d isr_clr", i), 8'(isr_clr), 8'(vecs[i].e_clr));
            if (vecs[i].e_clr || vecs[i].rst)
                chk($sformatf("v%0d isr_clr_level", i), 8'(isr_clr_level),
                    8'(vecs[i].e_clr_lvl));
            chk($sformatf("v%0d inta_count", i), 8'(inta_count), 8'(vecs[i].e_cnt));
            chk($sformatf("v%0d data_out", i), data_out, vecs[i].e_data);
            chk($sformatf("v%0d data_oe", i), 8'(data_oe), 8'(vecs[i].e_oe));
        end

        // Hand sequence: one isr_set per sequence; a second EOI overwrites the pending one.
        begin
            int set_before;
            set_before = n_set;
            aeoi = 1'b1; int_level = 3'd6; int_req = 1'b1;
            tick();
            inta_n = 1'b0; tick(); tick();
            int_req = 1'b0;
            inta_n = 1'b1; tick(); tick();
            inta_n = 1'b0; tick(); tick();
            chk("ovw data_out", data_out, 8'h46);
            inta_n = 1'b1; tick();
            eoi_cmd = 1'b1; eoi_level = 3'd3; tick();
            chk("ovw aeoi clr", 8'(isr_clr), 8'd1);
            chk("ovw aeoi lvl", 8'(isr_clr_level), 8'd6);
            eoi_level = 3'd5; tick();
            chk("ovw eoi clr", 8'(isr_clr), 8'd1);
            chk("ovw eoi lvl", 8'(isr_clr_level), 8'd5);
            eoi_cmd = 1'b0; tick();
            chk("ovw clr done", 8'(isr_clr), 8'd0);
            chk("ovw set pulses", 8'(n_set - set_before), 8'd1);
        end

`ifdef PIC_INTA_TIMEOUT_EN
        // Abort: first INTA only, counter expires in GAP.
        begin
            logic       seen;
            logic [2:0] seen_lvl;
            seen = 1'b0; seen_lvl = '0;
            aeoi = 1'b0; int_level = 3'd2; int_req = 1'b1;
            tick();
            inta_n = 1'b0; tick(); tick();
            int_req = 1'b0; inta_n = 1'b1;
            for (int c = 0; c < 40 && !seen; c++) begin
                tick();
                if (isr_clr === 1'b1) begin
                    seen = 1'b1;
                    seen_lvl = isr_clr_level;
                end
            end
            chk("tmo clr seen", 8'(seen), 8'd1);
            chk("tmo clr lvl", 8'(seen_lvl), 8'd2);
            chk("tmo inta_count", 8'(inta_count), 8'd0);
            chk("tmo int_out", 8'(int_out), 8'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
